// File: rtl/decoder_scan_n_pkg.sv
// Shared types for the scanning N-to-2^N decoder family.
// State encoding and mode constants used by decoder_scan_n and its bench.
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2,
      BLANK  = 2'd3
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/result bundle for decoder_scan_n; master drives controls, slave owns outputs.
interface decoder_scan_n_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned OUT_N = 2 ** SEL_W;

   logic             enable;
   logic             mode;
   logic             load;
   logic [SEL_W-1:0] in;
   logic [OUT_N-1:0] out;
   logic [SEL_W-1:0] index;
   logic             wrap;

   modport master (output enable, output mode, output load, output in,
                   input  out,    input  index, input  wrap);
   modport slave  (input  enable, input  mode,  input  load, input  in,
                   output out,    output index, output wrap);
endinterface

// File: rtl/decoder_scan_n_n_to_m.sv
// Combinational active-low one-hot decoder; dis = 1 drives every output high.
module decoder_n_to_m #(
   parameter int unsigned SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel,
   input  logic                  dis,
   output logic [2**SEL_W-1:0]   y
);

   always_comb begin
      y = '1;
      if (!dis) y[sel] = 1'b0;
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N active-low decoder with autonomous dwell-timed scan mode.
// Optional macro DECODER_SCAN_BLANK_EN inserts a blank cycle after every scan advance.
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned DWELL = 4
) (
   input  logic           clk,
   input  logic           reset,
   decoder_scan_n_if.slave bus
);

   localparam int unsigned OUT_N = 2 ** SEL_W;
   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_t           state, nxt_state;
   logic [SEL_W-1:0] idx, nxt_idx;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic             wrap_r, nxt_wrap;
   logic [OUT_N-1:0] out_r, dec_out;
   logic             dis;

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cnt   = '0;
      nxt_wrap  = 1'b0;
      if (bus.enable) begin
         nxt_state = IDLE;
      end else if (bus.mode == MODE_DIRECT) begin
         nxt_state = DIRECT;
         nxt_idx   = bus.in;
      end else begin
         case (state)
            SCAN: begin
               if (bus.load) begin
                  nxt_idx = bus.in;
               end else if (cnt == CNT_LAST) begin
                  nxt_idx = idx + SEL_W'(1);
`ifdef DECODER_SCAN_BLANK_EN
                  nxt_state = BLANK;
`else
                  nxt_wrap  = &idx;
`endif
               end else begin
                  nxt_cnt = cnt + CNT_W'(1);
               end
            end
`ifdef DECODER_SCAN_BLANK_EN
            // Index already advanced on entry to BLANK, so landing on 0 means a wrap.
            BLANK: begin
               nxt_state = SCAN;
               if (bus.load) nxt_idx  = bus.in;
               else          nxt_wrap = (idx == '0);
            end
`endif
            default: nxt_state = SCAN;
         endcase
      end
   end

   assign dis = (nxt_state != DIRECT) && (nxt_state != SCAN);

   decoder_n_to_m #(.SEL_W(SEL_W)) u_dec (
      .sel (nxt_idx),
      .dis (dis),
      .y   (dec_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         wrap_r <= 1'b0;
         out_r  <= '1;
      end else begin
         state  <= nxt_state;
         idx    <= nxt_idx;
         cnt    <= nxt_cnt;
         wrap_r <= nxt_wrap;
         out_r  <= dec_out;
      end
   end

   assign bus.out   = out_r;
   assign bus.index = idx;
   assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed self-checking bench for decoder_scan_n (SEL_W = 3); honours DECODER_SCAN_BLANK_EN.
module tb_decoder_scan_n;
   import decoder_pkg::*;

`ifdef DECODER_SCAN_BLANK_EN
   localparam int unsigned DW = 2;
`else
   localparam int unsigned DW = 4;
`endif

   logic clk = 1'b0;
   logic reset;
   int   nchk = 0;
   int   nerr = 0;

   decoder_scan_n_if #(.SEL_W(3)) bus ();

   decoder_scan_n #(.SEL_W(3), .DWELL(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [7:0] o, input logic [2:0] i, input logic w);
      chk({tag, ".out"},   32'(bus.out),   32'(o));
      chk({tag, ".index"}, 32'(bus.index), 32'(i));
      chk({tag, ".wrap"},  32'(bus.wrap),  32'(w));
   endtask

   initial begin
      logic [7:0] e;
      reset      = 1'b1;
      bus.enable = 1'b0;
      bus.mode   = MODE_SCAN;
      bus.load   = 1'b0;
      bus.in     = 3'd0;
      repeat (3) begin
         tick();
         chk3("reset", 8'hFF, 3'd0, 1'b0);
      end
      reset      = 1'b0;
      bus.enable = 1'b1;
      #2;
      chk3("release", 8'hFF, 3'd0, 1'b0);
      tick();
      chk3("idle", 8'hFF, 3'd0, 1'b0);

      bus.enable = 1'b0;
      bus.mode   = MODE_DIRECT;
      bus.in     = 3'd5;
      tick();
      chk3("direct5", 8'hDF, 3'd5, 1'b0);
      bus.in = 3'd0;
      tick();
      chk3("direct0", 8'hFE, 3'd0, 1'b0);

`ifndef DECODER_SCAN_BLANK_EN
      bus.in = 3'd6;
      tick();
      chk3("direct6", 8'hBF, 3'd6, 1'b0);
      bus.mode = MODE_SCAN;
      repeat (4) begin tick(); chk3("scan6", 8'hBF, 3'd6, 1'b0); end
      repeat (4) begin tick(); chk3("scan7", 8'h7F, 3'd7, 1'b0); end
      tick();
      chk3("wrap", 8'hFE, 3'd0, 1'b1);
      tick();
      chk3("wrap_once", 8'hFE, 3'd0, 1'b0);
      repeat (2) begin tick(); chk3("scan0", 8'hFE, 3'd0, 1'b0); end
      repeat (4) begin tick(); chk3("scan1", 8'hFD, 3'd1, 1'b0); end
      repeat (4) begin tick(); chk3("scan2", 8'hFB, 3'd2, 1'b0); end

      bus.load = 1'b1;
      bus.in   = 3'd7;
      tick();
      chk3("load_prio", 8'h7F, 3'd7, 1'b0);
      bus.load = 1'b0;
      repeat (3) begin tick(); chk3("load_dwell", 8'h7F, 3'd7, 1'b0); end
      tick();
      chk3("load_wrap", 8'hFE, 3'd0, 1'b1);

      bus.load = 1'b1;
      bus.in   = 3'd3;
      tick();
      chk3("load3", 8'hF7, 3'd3, 1'b0);
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      tick();
      chk3("disable", 8'hFF, 3'd3, 1'b0);
      tick();
      chk3("disable2", 8'hFF, 3'd3, 1'b0);
      bus.enable = 1'b0;
      repeat (4) begin tick(); chk3("resume", 8'hF7, 3'd3, 1'b0); end
      tick();
      chk3("resume_adv", 8'hEF, 3'd4, 1'b0);

      bus.mode = MODE_DIRECT;
      bus.load = 1'b1;
      bus.in   = 3'd2;
      tick();
      chk3("scan2direct", 8'hFB, 3'd2, 1'b0);
      bus.in = 3'd1;
      tick();
      chk3("direct_noload", 8'hFD, 3'd1, 1'b0);
      bus.load = 1'b0;
      bus.mode = MODE_SCAN;
      tick();
      chk3("direct2scan", 8'hFD, 3'd1, 1'b0);
      reset    = 1'b1;
      bus.load = 1'b1;
      tick();
      chk3("reset_mid", 8'hFF, 3'd0, 1'b0);
      reset    = 1'b0;
      bus.load = 1'b0;
`else
      bus.mode = MODE_SCAN;
      for (int k = 0; k < 24; k++) begin
         int p;
         p = k / 3;
         tick();
         if (k % 3 == 2) begin
            chk3("blank", 8'hFF, 3'((p + 1) % 8), 1'b0);
         end else begin
            e = ~(8'd1 << p);
            chk3("bscan", e, 3'(p), 1'b0);
         end
      end
      tick();
      chk3("bwrap", 8'hFE, 3'd0, 1'b1);
      tick();
      chk3("bwrap_once", 8'hFE, 3'd0, 1'b0);
      tick();
      chk3("blank1", 8'hFF, 3'd1, 1'b0);
      bus.load = 1'b1;
      bus.in   = 3'd5;
      tick();
      chk3("blank_load", 8'hDF, 3'd5, 1'b0);
      bus.load = 1'b0;
      tick();
      chk3("bload_dwell", 8'hDF, 3'd5, 1'b0);
      tick();
      chk3("blank6", 8'hFF, 3'd6, 1'b0);
      tick();
      chk3("bscan6", 8'hBF, 3'd6, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Registered, parametrised N-to-2^N decoder with active-low outputs and active-high disable, plus an autonomous scan mode that walks the one-hot-low output through every position with a programmable dwell time. It is the next-generation replacement for the fixed 3-to-8 decoder. It drives row/digit select lines for multiplexed LED and keypad matrices, and also works as a plain clocked address decoder.

## Interface
- SEL_W, 3: select width; OUT_N = 2**SEL_W outputs (derived localparam, not overridable); SEL_W >= 1.
- DWELL, 4: cycles each scan position is held; DWELL >= 1.
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  active-high *disable*: 1 forces all outputs high (inactive); 0 enables.
- mode  input  1  0 = direct decode of in, 1 = autonomous scan.
- load  input  1  scan mode only: load in as the scan index this cycle.
- in  input  SEL_W  select value (direct decode / scan load value).
- out  output  OUT_N  registered, active-low one-hot; all ones when inactive.
- index  output  SEL_W  registered position currently driven low (valid when active).
- wrap  output  1  one-cycle pulse when scan wraps OUT_N-1 -> 0.

## Operation
- States: IDLE (outputs inactive), DIRECT, SCAN, BLANK (BLANK only with macro, see Configuration).
- Reset: state IDLE, out = all ones, index = 0, wrap = 0, dwell counter = 0.
- Any state, enable = 1: next state IDLE, out = all ones, index held, dwell counter cleared, wrap = 0.
- IDLE/any, enable = 0, mode = 0: DIRECT; index <= in; out <= ~(1 << in).
- IDLE, enable = 0, mode = 1: SCAN starting at held index, fresh dwell. Resuming after disable restarts at the frozen index.
- SCAN: dwell counter counts 0..DWELL-1. At DWELL-1 the index advances by 1 modulo OUT_N and the counter clears. Advance OUT_N-1 -> 0 asserts wrap for the cycle out first shows position 0.
- SCAN, load = 1: index <= in, counter cleared, no wrap. Load beats advance in the same cycle. load is ignored in DIRECT/IDLE.
- DIRECT -> SCAN: scan begins at current index with fresh dwell. SCAN -> DIRECT: next cycle decodes in, and index <= in.
- DWELL = 1: index advances every cycle; counter logic degenerates cleanly (no zero-width vectors).
- Exactly one out bit is low whenever state is DIRECT or SCAN; none otherwise.

## Timing
- All outputs are registered; latency 1 cycle from any input change to out/index/wrap.
- Scan period = OUT_N * DWELL cycles without macro; OUT_N * (DWELL + 1) with macro.
- Reset asserted mid-scan takes effect on the next edge regardless of enable/mode/load.
- Reset has priority over enable, enable over mode, and load over advance.

## Configuration
- DECODER_SCAN_BLANK_EN defined: each scan advance inserts one BLANK cycle (out = all ones, wrap = 0, index already updated), then SCAN shows the new position. wrap is moved to the first cycle after the blank. This is an anti-ghosting gap. load during BLANK applies and skips the remaining blank.
- Undefined: no BLANK state; advances are back-to-back.
- Direct mode is unaffected either way.

## Structure
- Shared package decoder_pkg: state enum (IDLE, DIRECT, SCAN, BLANK) and a mode constant pair (MODE_DIRECT = 0, MODE_SCAN = 1).
- One sub-module: decoder_n_to_m, a combinational parametrised active-low decoder (enable-high-disables), instanced once on the next-index value and registered in the parent.
- Dwell counter width $clog2(DWELL) with minimum 1 bit.

## Test plan
- Reset: hold reset 3 cycles with enable = 0, mode = 1 -> out = 8'hFF, index = 0, wrap = 0 throughout and one cycle after release.
- Direct: SEL_W = 3, enable = 0, mode = 0, in = 5 -> next cycle out = 8'hDF, index = 5; in = 0 -> out = 8'hFE.
- Scan and wrap: DWELL = 4, scan from index 6 -> out = 8'hBF for 4 cycles, then 8'h7F for 4, then 8'hFE with wrap = 1 for exactly one cycle.
- Load priority: at the dwell-final cycle of index 2, load = 1, in = 7 -> next out = 8'h7F, not 8'hF7; no wrap.
- Disable mid-scan: enable = 1 at index 3 -> out = 8'hFF next cycle. enable = 0 later -> index 3 (8'hF7) for a full 4-cycle dwell.
- Macro build: DECODER_SCAN_BLANK_EN, DWELL = 2 -> pattern FE, FE, FF, FD, FD, FF, ...; period 24 cycles; wrap on the cycle after the blank that follows 7F.
